// File: rtl/dynamic_branch_predictor_if.sv
// dynamic_branch_predictor_if: fetch lookup, execute resolve and flush/redirect bundle; BP_STATS_EN adds counters
interface dynamic_branch_predictor_if #(
  parameter int PC_WIDTH = 32
);
  logic                lookup_valid;
  logic [PC_WIDTH-1:0] lookup_pc;
  logic                pred_taken;
  logic [2:0]          unitID_EX;
  logic                resolve_valid;
  logic [PC_WIDTH-1:0] resolve_pc;
  logic                resolve_taken;
  logic                resolve_pred;
  logic [PC_WIDTH-1:0] resolve_target;
  logic                flushEven;
  logic                flushOdd;
  logic [PC_WIDTH-1:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0]         stat_branches;
  logic [31:0]         stat_mispredicts;
`endif
  modport master (
    output lookup_valid, lookup_pc, unitID_EX, resolve_valid, resolve_pc,
           resolve_taken, resolve_pred, resolve_target,
    input  pred_taken, flushEven, flushOdd, redirect_pc
`ifdef BP_STATS_EN
    , input stat_branches, stat_mispredicts
`endif
  );
  modport slave (
    input  lookup_valid, lookup_pc, unitID_EX, resolve_valid, resolve_pc,
           resolve_taken, resolve_pred, resolve_target,
    output pred_taken, flushEven, flushOdd, redirect_pc
`ifdef BP_STATS_EN
    , output stat_branches, stat_mispredicts
`endif
  );
endinterface

// File: rtl/dynamic_branch_predictor.sv
// dynamic_branch_predictor: PC-indexed saturating-counter predictor with mispredict flush/redirect; BP_STATS_EN adds branch/mispredict counters
module dynamic_branch_predictor #(
  parameter int PC_WIDTH       = 32,
  parameter int INDEX_BITS     = 6,
  parameter int CTR_BITS       = 2,
  parameter int BRANCH_UNIT_ID = 7
) (
  input logic clk,
  input logic reset,
  dynamic_branch_predictor_if.slave bus
);
  localparam int ENTRIES = 2 ** INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [CTR_BITS-1:0] table_q [ENTRIES];
  logic [CTR_BITS-1:0] table_d [ENTRIES];
  logic [PC_WIDTH-1:0] redirect_q, redirect_d;
  logic [INDEX_BITS-1:0] lk_idx, rs_idx;
  logic [CTR_BITS-1:0] rs_ctr;
  logic shadow, br_res, mispredict;
  logic unused_pc;
  assign lk_idx = bus.lookup_pc[INDEX_BITS+1:2];
  assign rs_idx = bus.resolve_pc[INDEX_BITS+1:2];
  assign rs_ctr = table_q[rs_idx];
  assign unused_pc = ^{bus.lookup_pc[PC_WIDTH-1:INDEX_BITS+2], bus.lookup_pc[1:0]};
  assign shadow = state_q == FLUSH;
  assign br_res = bus.resolve_valid & (bus.unitID_EX == 3'(BRANCH_UNIT_ID)) & ~shadow;
  assign mispredict = br_res & (bus.resolve_taken != bus.resolve_pred);
  assign bus.pred_taken = bus.lookup_valid & table_q[lk_idx][CTR_BITS-1];
  assign bus.flushEven = shadow;
  assign bus.flushOdd = shadow;
  assign bus.redirect_pc = redirect_q;
  // next-state: counter training, one-cycle flush after a mispredict, redirect capture
  always_comb begin
    table_d = table_q;
    table_d[rs_idx] = !br_res ? rs_ctr :
                      bus.resolve_taken ? (rs_ctr == CTR_MAX ? rs_ctr : rs_ctr + 1'b1) :
                      (rs_ctr == '0 ? rs_ctr : rs_ctr - 1'b1);
    state_d = mispredict ? FLUSH : RUN;
    redirect_d = !mispredict ? redirect_q :
                 bus.resolve_taken ? bus.resolve_target : bus.resolve_pc + PC_WIDTH'(4);
  end
  // state, table and redirect registers; reset reloads every counter to weakly not-taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      redirect_q <= '0;
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_INIT;
    end else begin
      state_q <= state_d;
      redirect_q <= redirect_d;
      table_q <= table_d;
    end
  end
`ifdef BP_STATS_EN
  logic [31:0] stat_br_q, stat_br_d, stat_mis_q, stat_mis_d;
  assign bus.stat_branches = stat_br_q;
  assign bus.stat_mispredicts = stat_mis_q;
  // saturating event counters; shadow-dropped resolves never reach br_res
  always_comb begin
    stat_br_d = (br_res && stat_br_q != '1) ? stat_br_q + 1'b1 : stat_br_q;
    stat_mis_d = (mispredict && stat_mis_q != '1) ? stat_mis_q + 1'b1 : stat_mis_q;
  end
  // statistics registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_br_q <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end
`endif
endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// tb_dynamic_branch_predictor: directed plus random stimulus against a behavioural predictor model
module tb_dynamic_branch_predictor;
  logic clk = 0;
  logic reset = 1;
  int tests = 0;
  int fails = 0;
  int m_ctr [64];
  bit m_flush;
  logic [31:0] m_redir;
  int m_br, m_mis;
  dynamic_branch_predictor_if #(.PC_WIDTH(32)) bus ();
  dynamic_branch_predictor dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_ctr[i] = 1;
    m_flush = 0;
    m_redir = 0;
    m_br = 0;
    m_mis = 0;
  endtask
  task automatic check_outputs();
    check("flushEven", 32'(bus.flushEven), 32'(m_flush));
    check("flushOdd", 32'(bus.flushOdd), 32'(m_flush));
    check("redirect_pc", bus.redirect_pc, m_redir);
`ifdef BP_STATS_EN
    check("stat_branches", bus.stat_branches, m_br);
    check("stat_mispredicts", bus.stat_mispredicts, m_mis);
`endif
  endtask
  task automatic model_edge();
    int idx;
    bit br, mis;
    idx = int'((bus.resolve_pc >> 2) & 32'd63);
    br = bus.resolve_valid && bus.unitID_EX == 3'd7 && !m_flush;
    mis = br && (bus.resolve_taken != bus.resolve_pred);
    if (br) begin
      if (bus.resolve_taken) m_ctr[idx] = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
      else m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
      m_br++;
    end
    if (mis) begin
      m_mis++;
      m_redir = bus.resolve_taken ? bus.resolve_target : bus.resolve_pc + 32'd4;
    end
    m_flush = mis;
  endtask
  task automatic cycle();
    int lidx;
    #1;
    lidx = int'((bus.lookup_pc >> 2) & 32'd63);
    check("pred_taken", 32'(bus.pred_taken), 32'(bus.lookup_valid && m_ctr[lidx] >= 2));
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask
  task automatic set_idle();
    bus.lookup_valid = 0;
    bus.lookup_pc = 0;
    bus.unitID_EX = 0;
    bus.resolve_valid = 0;
    bus.resolve_pc = 0;
    bus.resolve_taken = 0;
    bus.resolve_pred = 0;
    bus.resolve_target = 0;
  endtask
  task automatic resolve(input logic [31:0] pc, input bit tk, input bit pr, input logic [31:0] tgt, input logic [2:0] uid);
    set_idle();
    bus.resolve_valid = 1;
    bus.unitID_EX = uid;
    bus.resolve_pc = pc;
    bus.resolve_taken = tk;
    bus.resolve_pred = pr;
    bus.resolve_target = tgt;
    cycle();
  endtask
  task automatic lookup(input logic [31:0] pc);
    set_idle();
    bus.lookup_valid = 1;
    bus.lookup_pc = pc;
    cycle();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
    check_outputs();
    lookup(32'h100);
    resolve(32'h100, 1, 0, 32'h400, 7);
    lookup(32'h100);
    resolve(32'h100, 1, 1, 32'h400, 7);
    lookup(32'h100);
    repeat (5) resolve(32'h100, 1, 1, 32'h500, 7);
    lookup(32'h100);
    repeat (2) resolve(32'h100, 0, 0, 32'h500, 7);
    lookup(32'h100);
    resolve(32'h200, 0, 1, 32'h800, 7);
    lookup(32'h0);
    resolve(32'hFFFFFFFC, 0, 1, 32'h800, 7);
    lookup(32'hFFFFFFFC);
    resolve(32'h100, 1, 0, 32'h900, 7);
    resolve(32'h304, 1, 0, 32'hA00, 7);
    lookup(32'h304);
    lookup(32'h304);
    resolve(32'h100, 1, 0, 32'hB00, 3);
    lookup(32'h100);
    resolve(32'h100, 1, 1, 32'hC00, 7);
    lookup(32'h200);
    bus.lookup_valid = 1;
    bus.lookup_pc = 32'h200;
    bus.resolve_valid = 1;
    bus.unitID_EX = 7;
    bus.resolve_pc = 32'h100;
    bus.resolve_taken = 1;
    bus.resolve_pred = 1;
    cycle();
    lookup(32'h100);
    resolve(32'h100, 0, 1, 32'hD00, 7);
    check("flush_before_reset", 32'(bus.flushEven), 32'd1);
    #1 reset = 1;
    #1;
    check("async_flushEven", 32'(bus.flushEven), 32'd0);
    check("async_flushOdd", 32'(bus.flushOdd), 32'd0);
    model_reset();
    set_idle();
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
    check_outputs();
    lookup(32'h100);
    resolve(32'h40, 1, 1, 32'h0, 7);
    resolve(32'h44, 0, 0, 32'h0, 7);
    resolve(32'h48, 1, 0, 32'h1234, 7);
    lookup(32'h48);
    for (int n = 0; n < 400; n++) begin
      set_idle();
      bus.lookup_valid = 1'($urandom_range(0, 1));
      bus.lookup_pc = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 8) | 32'($urandom_range(0, 3));
      bus.resolve_valid = 1'($urandom_range(0, 3) != 0);
      bus.unitID_EX = ($urandom_range(0, 3) != 0) ? 3'd7 : 3'($urandom_range(0, 6));
      bus.resolve_pc = ($urandom_range(0, 19) == 0) ? 32'hFFFFFFFC : (($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 8));
      bus.resolve_taken = 1'($urandom_range(0, 1));
      bus.resolve_pred = ($urandom_range(0, 2) == 0) ? ~bus.resolve_taken : bus.resolve_taken;
      bus.resolve_target = $urandom & 32'hFFFFFFFC;
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
